defuzz_wavg: RTL and testbench

Weighted-average (singleton centroid) defuzzifier for the dT output path: takes three rule-firing strengths in Q1.15 (neg/zero/pos) with their signed 8-bit singleton positions and produces a crisp signed 8-bit result, y = Σ(mu_i·s_i) / Σ(mu_i). It sits downstream of rule evaluation and is the inverse end of the dT fuzzification chain. A sequential restoring divider produces the quotient, with valid/ready handshakes on both input and output.

---
 rtl/fuzzy_pkg.sv | 32 +++
 rtl/seq_div_u.sv | 66 ++++++
 rtl/defuzz_wavg.sv | 149 ++++++++++++++
 tb/tb_defuzz_wavg.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fuzzy_pkg.sv
// Shared fuzzy-path types and widths: Q1.15 strengths, singleton positions,
// defuzzifier accumulator widths and the defuzzifier state encoding.
package fuzzy_pkg;

  localparam logic [15:0] Q15_ONE = 16'h8000;
  localparam int MU_W  = 16;
  localparam int POS_W = 8;
  localparam int NUM_W = 26;
  localparam int DEN_W = 18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } defuzz_state_e;

  // Strengths above 1.0 are treated as exactly 1.0.
  function automatic logic [MU_W-1:0] clamp_mu(input logic [MU_W-1:0] m);
    return (m > Q15_ONE) ? Q15_ONE : m;
  endfunction

  // Unsigned strength times signed position.
  // The full product needs 24 bits; it is carried at the 26-bit sum width.
  function automatic logic signed [NUM_W-1:0] mu_term(input logic [MU_W-1:0] m,
                                                      input logic [POS_W-1:0] s);
    logic signed [NUM_W-1:0] a, b;
    a = $signed({{(NUM_W-MU_W){1'b0}}, m});
    b = $signed({{(NUM_W-POS_W){s[POS_W-1]}}, s});
    return a * b;
  endfunction

endpackage

// File: rtl/seq_div_u.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// The quotient must fit in DIV_ITERS bits. done is high during the final
// iteration cycle, and quotient carries the completed result in that cycle,
// so the caller can register it on the same edge that finishes the divide.
module seq_div_u #(
  parameter int DIV_ITERS = 9,
  parameter int NUM_W     = 26,
  parameter int DEN_W     = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_W-1:0]     dividend,
  input  logic [DEN_W-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic [DIV_ITERS-1:0] quotient
);
  localparam int RW = NUM_W + DIV_ITERS;
  localparam int CW = $clog2(DIV_ITERS + 1);

  logic [RW-1:0]        rem_q, rem_d, dsr_q, dsr_d;
  logic [DIV_ITERS-1:0] quo_q, quo_d, quo_step;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ge;

  // Trial subtract against a divisor that starts aligned to the top quotient bit.
  always_comb begin
    ge       = rem_q >= dsr_q;
    quo_step = {quo_q[DIV_ITERS-2:0], ge};
    busy     = cnt_q != '0;
    done     = cnt_q == CW'(1);
    quotient = quo_step;
    rem_d    = rem_q;
    dsr_d    = dsr_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    if (start) begin
      rem_d = RW'(dividend);
      dsr_d = RW'(divisor) << (DIV_ITERS - 1);
      quo_d = '0;
      cnt_d = CW'(DIV_ITERS);
    end else if (busy) begin
      if (ge) rem_d = rem_q - dsr_q;
      dsr_d = dsr_q >> 1;
      quo_d = quo_step;
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Divider state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      dsr_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      dsr_q <= dsr_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/defuzz_wavg.sv
// Singleton-centroid defuzzifier: y = sum(mu_i*s_i) / sum(mu_i), signed 8-bit.
// Sign-magnitude around an unsigned sequential divider; result saturated.
// Build option DEFUZZ_ROUND_EN: round half away from zero instead of truncating.
module defuzz_wavg
  import fuzzy_pkg::*;
#(
  parameter int DIV_ITERS = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [MU_W-1:0]         mu_neg,
  input  logic [MU_W-1:0]         mu_zero,
  input  logic [MU_W-1:0]         mu_pos,
  input  logic signed [POS_W-1:0] s_neg,
  input  logic signed [POS_W-1:0] s_zero,
  input  logic signed [POS_W-1:0] s_pos,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [POS_W-1:0] y,
  output logic                    no_fire
);

  defuzz_state_e state_q, state_d;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic no_fire_q, no_fire_d, neg_q, neg_d;
  logic signed [POS_W-1:0] y_q, y_d, y_sat;

  logic [MU_W-1:0]         mu_n_c, mu_z_c, mu_p_c;
  logic signed [NUM_W-1:0] num_c;
  logic [NUM_W-1:0]        mag_c, dividend_c;
  logic [DEN_W-1:0]        den_c;
  logic signed [DIV_ITERS:0] qv;

  logic                 div_start, div_busy, div_done;
  logic [DIV_ITERS-1:0] div_quo;

  // Operand conditioning: clamp, weighted sums, magnitude and rounding bias.
  always_comb begin
    mu_n_c = clamp_mu(mu_neg);
    mu_z_c = clamp_mu(mu_zero);
    mu_p_c = clamp_mu(mu_pos);
    num_c  = mu_term(mu_n_c, s_neg) + mu_term(mu_z_c, s_zero) + mu_term(mu_p_c, s_pos);
    den_c  = DEN_W'(mu_n_c) + DEN_W'(mu_z_c) + DEN_W'(mu_p_c);
    mag_c  = num_c[NUM_W-1] ? -num_c : num_c;
`ifdef DEFUZZ_ROUND_EN
    dividend_c = mag_c + NUM_W'(den_c >> 1);
`else
    dividend_c = mag_c;
`endif
    div_start = (state_q == ST_IDLE) && in_valid && (den_c != '0);
  end

  seq_div_u #(
    .DIV_ITERS(DIV_ITERS),
    .NUM_W    (NUM_W),
    .DEN_W    (DEN_W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start),
    .dividend(dividend_c),
    .divisor (den_c),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_quo)
  );

  // Reapply the sign and saturate to the signed 8-bit range.
  always_comb begin
    qv = neg_q ? -$signed({1'b0, div_quo}) : $signed({1'b0, div_quo});
    if (qv > $signed((DIV_ITERS + 1)'(127)))       y_sat = 8'sh7F;
    else if (qv < -$signed((DIV_ITERS + 1)'(128))) y_sat = 8'sh80;
    else                                           y_sat = qv[POS_W-1:0];
  end

  // Next-state and registered-output logic for IDLE/DIV/DONE.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    no_fire_d   = no_fire_q;
    neg_d       = neg_q;
    unique case (state_q)
      ST_IDLE: if (in_valid) begin
        in_ready_d = 1'b0;
        neg_d      = num_c[NUM_W-1];
        if (den_c == '0) begin
          // Nothing fired: no divide, result is a forced zero.
          state_d   = ST_DONE;
          y_d       = '0;
          no_fire_d = 1'b1;
        end else begin
          state_d   = ST_DIV;
          no_fire_d = 1'b0;
        end
      end
      ST_DIV: if (div_done) begin
        state_d     = ST_DONE;
        out_valid_d = 1'b1;
        y_d         = y_sat;
      end else if (!div_busy) begin
        // Divider lost its operation; drop the transaction rather than hang.
        state_d    = ST_IDLE;
        in_ready_d = 1'b1;
      end
      ST_DONE: if (!out_valid_q) begin
        // No-fire path arrives here with valid still low; present it next cycle.
        out_valid_d = 1'b1;
      end else if (out_ready) begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // FSM state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      no_fire_q   <= 1'b0;
      neg_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      no_fire_q   <= no_fire_d;
      neg_q       <= neg_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign no_fire   = no_fire_q;

endmodule

// File: tb/tb_defuzz_wavg.sv
// Scoreboard bench for defuzz_wavg: expected results pushed on accept,
// popped and compared when out_valid appears. Honors DEFUZZ_ROUND_EN.
module tb_defuzz_wavg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, no_fire;
  logic [15:0] mu_neg = '0, mu_zero = '0, mu_pos = '0;
  logic signed [7:0] s_neg = '0, s_zero = '0, s_pos = '0;
  logic signed [7:0] y;

  always #5 clk = ~clk;

  defuzz_wavg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mu_neg(mu_neg), .mu_zero(mu_zero), .mu_pos(mu_pos),
    .s_neg(s_neg), .s_zero(s_zero), .s_pos(s_pos),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .no_fire(no_fire)
  );

  typedef struct { int y; int nf; int lat; } exp_t;
  exp_t sb[$];
  int n_pass = 0, n_tot = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, act, exp);
  endtask

  function automatic exp_t model(input int mn, mz, mp, sn, sz, sp);
    exp_t e;
    int num, den, mag, q;
    if (mn > 32768) mn = 32768;
    if (mz > 32768) mz = 32768;
    if (mp > 32768) mp = 32768;
    num = mn * sn + mz * sz + mp * sp;
    den = mn + mz + mp;
    if (den == 0) begin
      e.y = 0; e.nf = 1; e.lat = 1;
      return e;
    end
    mag = (num < 0) ? -num : num;
`ifdef DEFUZZ_ROUND_EN
    mag = mag + den / 2;
`endif
    q = mag / den;
    e.y = (num < 0) ? -q : q;
    if (e.y > 127) e.y = 127;
    if (e.y < -128) e.y = -128;
    e.nf = 0; e.lat = 9;
    return e;
  endfunction

  task automatic drive(input int mn, mz, mp, sn, sz, sp);
    mu_neg = 16'(mn); mu_zero = 16'(mz); mu_pos = 16'(mp);
    s_neg = 8'(sn); s_zero = 8'(sz); s_pos = 8'(sp);
  endtask

  // Present one operand set; accepted on the next edge (block is idle).
  task automatic send(input int mn, mz, mp, sn, sz, sp);
    @(negedge clk);
    drive(mn, mz, mp, sn, sz, sp);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    sb.push_back(model(mn, mz, mp, sn, sz, sp));
  endtask

  // Wait for the result, compare, hold it under backpressure, then release.
  task automatic collect(input string tag, input int hold);
    exp_t e;
    int lat = 0;
    int y0, nf0;
    forever begin
      @(negedge clk);
      if (out_valid || lat >= 40) break;
      lat++;
    end
    chk({tag, "_valid"}, int'(out_valid), 1);
    e = sb.pop_front();
    chk({tag, "_lat"}, lat, e.lat);
    chk({tag, "_y"}, int'(y), e.y);
    chk({tag, "_nofire"}, int'(no_fire), e.nf);
    y0 = int'(y); nf0 = int'(no_fire);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, int'(out_valid), 1);
      chk({tag, "_hold_y"}, int'(y), y0);
      chk({tag, "_hold_nofire"}, int'(no_fire), nf0);
      chk({tag, "_hold_inrdy"}, int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, "_rel_inrdy"}, int'(in_ready), 1);
    chk({tag, "_rel_valid"}, int'(out_valid), 0);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_inrdy", int'(in_ready), 1);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_nofire", int'(no_fire), 0);
    rst = 1'b0;

    send(0, 32768, 0, -64, 0, 64);         collect("centre", 0);
    send(16384, 0, 16384, -100, 0, 50);    collect("neg25", 0);
    send(0, 32768, 32768, 0, 0, 3);        collect("rnd_pos", 0);
    send(32768, 32768, 0, -3, 0, 0);       collect("rnd_neg", 0);
    send(0, 0, 0, -5, 17, 99);             collect("nofire", 5);
    send(0, 0, 65535, 0, 0, 127);          collect("clamp", 5);
    send(65535, 0, 0, -128, 0, 0);         collect("sat_neg", 0);
    send(65535, 65535, 65535, 127, 127, 127); collect("all_max", 0);
    send(1, 0, 0, -128, 0, 0);             collect("tiny", 0);

    for (int i = 0; i < 20; i++) begin
      send((i % 4 == 0) ? 0 : int'($urandom_range(0, 65535)),
           int'($urandom_range(0, 65535)),
           (i % 5 == 0) ? 0 : int'($urandom_range(0, 40000)),
           int'($urandom_range(0, 255)) - 128,
           int'($urandom_range(0, 255)) - 128,
           int'($urandom_range(0, 255)) - 128);
      collect("rand", i % 3);
    end

    // Output handshake and new operands offered in the same DONE cycle.
    send(16384, 0, 16384, -100, 0, 50);
    begin
      exp_t e;
      int lat = 0;
      forever begin
        @(negedge clk);
        if (out_valid || lat >= 40) break;
        lat++;
      end
      e = sb.pop_front();
      chk("ovl_valid", int'(out_valid), 1);
      chk("ovl_y", int'(y), e.y);
      out_ready = 1'b1;
      in_valid = 1'b1;
      drive(0, 32768, 32768, 0, 0, 3);
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk("ovl_inrdy", int'(in_ready), 1);
      chk("ovl_out_low", int'(out_valid), 0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      sb.push_back(model(0, 32768, 32768, 0, 0, 3));
      collect("ovl_next", 0);
    end

    // Reset in the middle of a divide discards the result.
    send(16384, 0, 16384, -100, 0, 50);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_front());
    chk("mrst_valid", int'(out_valid), 0);
    chk("mrst_inrdy", int'(in_ready), 1);
    chk("mrst_y", int'(y), 0);
    chk("mrst_nofire", int'(no_fire), 0);
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (out_valid) seen = 1;
      end
      chk("mrst_no_late_out", seen, 0);
    end
    send(0, 32768, 0, -64, 0, 64);         collect("post_rst", 1);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
